spice_step_sequencer: RTL and testbench

SPICE_STEP_SEQUENCER -- requirements
Module: spice_step_sequencer

---
 rtl/spice_step_sequencer_pkg.sv | 17 +
 rtl/spice_step_sequencer_if.sv | 31 +++
 rtl/spice_step_sequencer_settle_counter.sv | 62 ++++++
 rtl/spice_step_sequencer.sv | 110 +++++++++++
 tb/tb_spice_step_sequencer.sv | 272 +++++++++++++++++++++++++++
 5 files changed

// File: rtl/spice_step_sequencer_pkg.sv
// Shared definitions for the SPICE step sequencer slice.
//   ITER_MAX_DEF   : default maximum solver iterations per simulated half-cycle
//   SETTLE_MIN_DEF : default number of consecutive settled iterations that end a half-cycle
//   seq_state_t    : sequencer FSM states
package spice_step_sequencer_pkg;

    localparam int unsigned ITER_MAX_DEF   = 16;
    localparam int unsigned SETTLE_MIN_DEF = 4;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_DRIVE,
        ST_ITERATE,
        ST_DONE
    } seq_state_t;

endpackage

// File: rtl/spice_step_sequencer_if.sv
// Control/status bundle between the sequencer and its controller / node array.
//   run, step_req, settled_i : requests and node-array status into the sequencer
//   upd_en, phi_pin          : node integrator enable and simulated chip clock level
//   step_ack, busy           : single-step completion pulse, non-idle indication
//   iter_cnt, halfcycle_cnt  : iteration count of current/last half-cycle, completed half-cycles
//   timeout                  : sticky flag, a half-cycle ran out of iterations
// master = controller side, slave = sequencer side.
interface spice_step_sequencer_if;

    logic        run;
    logic        step_req;
    logic        settled_i;
    logic        upd_en;
    logic        phi_pin;
    logic        step_ack;
    logic        busy;
    logic [7:0]  iter_cnt;
    logic [31:0] halfcycle_cnt;
    logic        timeout;

    modport master (
        output run, step_req, settled_i,
        input  upd_en, phi_pin, step_ack, busy, iter_cnt, halfcycle_cnt, timeout
    );

    modport slave (
        input  run, step_req, settled_i,
        output upd_en, phi_pin, step_ack, busy, iter_cnt, halfcycle_cnt, timeout
    );

endinterface

// File: rtl/spice_step_sequencer_settle_counter.sv
// Iteration and settle counting for one half-cycle.
//   clk, reset : clock, synchronous active-high reset
//   settled_i  : node array reports all currents below threshold this cycle
//   clear      : zero both counters (asserted on the edge entering DRIVE)
//   en         : count this cycle (ITERATE)
//   settled    : this iteration brings the settle streak to SETTLE_MIN
//   iter_cnt   : iterations spent so far (held when en is low)
//   saturated  : this iteration brings iter_cnt to ITER_MAX
module spice_settle_counter
    import spice_step_sequencer_pkg::*;
#(
    parameter int unsigned ITER_MAX   = ITER_MAX_DEF,
    parameter int unsigned SETTLE_MIN = SETTLE_MIN_DEF
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       settled_i,
    input  logic       clear,
    input  logic       en,
    output logic       settled,
    output logic [7:0] iter_cnt,
    output logic       saturated
);

    localparam logic [7:0] ITER_LIM   = 8'(ITER_MAX);
    localparam logic [7:0] SETTLE_LIM = 8'(SETTLE_MIN);

    logic [7:0] iter_q;
    logic [7:0] iter_nx;
    logic [7:0] settle_q;
    logic [7:0] settle_nx;

    always_comb begin
        iter_nx   = iter_q;
        settle_nx = settle_q;
        if (iter_q != ITER_LIM) begin
            iter_nx = iter_q + 8'd1;
        end
        if (!settled_i) begin
            settle_nx = '0;
        end else if (settle_q != SETTLE_LIM) begin
            settle_nx = settle_q + 8'd1;
        end
    end

    always_ff @(posedge clk) begin
        if (reset || clear) begin
            iter_q   <= '0;
            settle_q <= '0;
        end else if (en) begin
            iter_q   <= iter_nx;
            settle_q <= settle_nx;
        end
    end

    // Look-ahead flags so the FSM leaves ITERATE on the same edge that
    // records the final iteration.
    assign settled   = en && (settle_nx == SETTLE_LIM);
    assign saturated = en && (iter_nx == ITER_LIM);
    assign iter_cnt  = iter_q;

endmodule

// File: rtl/spice_step_sequencer.sv
// Sequences one simulated chip half-cycle at a time for a switch-level
// node solver: toggles the simulated clock pin, then enables node
// integration until the network settles or the iteration budget runs out.
//   clk, reset : clock, synchronous active-high reset
//   bus        : slave side of spice_step_sequencer_if
//                (run, step_req, settled_i in; upd_en, phi_pin, step_ack,
//                 busy, iter_cnt, halfcycle_cnt, timeout out)
module spice_step_sequencer
    import spice_step_sequencer_pkg::*;
#(
    parameter int unsigned ITER_MAX   = ITER_MAX_DEF,
    parameter int unsigned SETTLE_MIN = SETTLE_MIN_DEF
) (
    input  logic                  clk,
    input  logic                  reset,
    spice_step_sequencer_if.slave bus
);

    seq_state_t  state;
    logic        single_q;
    logic        upd_en_q;
    logic        phi_q;
    logic        ack_q;
    logic [31:0] hc_q;
    logic        timeout_q;

    logic        start;
    logic        cnt_en;
    logic        cnt_settled;
    logic        cnt_saturated;
    logic [7:0]  cnt_iter;

    // A new half-cycle begins from IDLE on run or a lone step_req, or
    // directly from DONE while run stays high.
    assign start  = ((state == ST_IDLE) && (bus.run || bus.step_req)) ||
                    ((state == ST_DONE) && bus.run);
    assign cnt_en = (state == ST_ITERATE);

    spice_settle_counter #(
        .ITER_MAX   (ITER_MAX),
        .SETTLE_MIN (SETTLE_MIN)
    ) u_settle (
        .clk       (clk),
        .reset     (reset),
        .settled_i (bus.settled_i),
        .clear     (start),
        .en        (cnt_en),
        .settled   (cnt_settled),
        .iter_cnt  (cnt_iter),
        .saturated (cnt_saturated)
    );

    always_ff @(posedge clk) begin
        if (reset) begin
            state     <= ST_IDLE;
            single_q  <= 1'b0;
            upd_en_q  <= 1'b0;
            phi_q     <= 1'b0;
            ack_q     <= 1'b0;
            hc_q      <= '0;
            timeout_q <= 1'b0;
        end else begin
            ack_q <= 1'b0;
            case (state)
                ST_IDLE: begin
                    if (start) begin
                        state    <= ST_DRIVE;
                        phi_q    <= ~phi_q;
                        single_q <= ~bus.run;
                    end
                end
                ST_DRIVE: begin
                    state    <= ST_ITERATE;
                    upd_en_q <= 1'b1;
                end
                ST_ITERATE: begin
                    if (cnt_settled || cnt_saturated) begin
                        state    <= ST_DONE;
                        upd_en_q <= 1'b0;
                        hc_q     <= hc_q + 32'd1;
                        ack_q    <= single_q;
                        // Settling on the last permitted iteration is not a timeout.
                        if (!cnt_settled) begin
                            timeout_q <= 1'b1;
                        end
                    end
                end
                ST_DONE: begin
                    if (start) begin
                        state    <= ST_DRIVE;
                        phi_q    <= ~phi_q;
                        single_q <= 1'b0;
                    end else begin
                        state <= ST_IDLE;
                    end
                end
                default: state <= ST_IDLE;
            endcase
        end
    end

    assign bus.upd_en        = upd_en_q;
    assign bus.phi_pin       = phi_q;
    assign bus.step_ack      = ack_q;
    assign bus.busy          = (state != ST_IDLE);
    assign bus.iter_cnt      = cnt_iter;
    assign bus.halfcycle_cnt = hc_q;
    assign bus.timeout       = timeout_q;

endmodule

// File: tb/tb_spice_step_sequencer.sv
module tb_spice_step_sequencer;

    localparam int ITER_MAX   = 16;
    localparam int SETTLE_MIN = 4;

    logic clk = 1'b0;
    logic reset;

    spice_step_sequencer_if bus ();

    spice_step_sequencer #(
        .ITER_MAX   (ITER_MAX),
        .SETTLE_MIN (SETTLE_MIN)
    ) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    always #5 clk = ~clk;

    int n_checks = 0;
    int n_pass   = 0;
    bit pat [0:255];
    bit exp_timeout = 1'b0;
    bit exp_phi     = 1'b0;
    int exp_hc      = 0;

    initial begin
        #2000000;
        $display("FAIL watchdog: got no finish expected finish before time limit");
        $fatal(1);
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Reference: iterations used and timeout outcome for the current pattern.
    function automatic void model_step(output int iters, output bit tmo);
        int streak = 0;
        iters = ITER_MAX;
        tmo   = 1'b1;
        for (int i = 0; i < ITER_MAX; i++) begin
            streak = pat[i] ? streak + 1 : 0;
            if (streak >= SETTLE_MIN) begin
                iters = i + 1;
                tmo   = 1'b0;
                return;
            end
        end
    endfunction

    // One single-step half-cycle; iteration n sees pat[n]. ack_cyc counts
    // cycles with the step_req cycle as cycle 0.
    task automatic run_step(output int ack_cyc, output int upd_cycles, output int n_acks);
        ack_cyc    = -1;
        upd_cycles = 0;
        n_acks     = 0;
        bus.step_req  = 1'b1;
        bus.settled_i = 1'($urandom_range(0, 1));
        tick();
        bus.step_req = 1'b0;
        for (int k = 1; k <= 300; k++) begin
            bus.settled_i = (k >= 2 && k - 2 < 256) ? pat[k-2] : 1'($urandom_range(0, 1));
            tick();
            if (bus.upd_en === 1'b1) upd_cycles++;
            if (bus.step_ack === 1'b1) begin
                n_acks++;
                if (ack_cyc < 0) ack_cyc = k + 1;
            end
            if (bus.busy === 1'b0) break;
        end
    endtask

    task automatic test_reset();
        reset = 1'b1;
        bus.run = 1'b0; bus.step_req = 1'b0; bus.settled_i = 1'b0;
        tick(); tick();
        n_checks++; if (bus.phi_pin !== 1'b0) $display("FAIL rst_phi: got %b expected 0", bus.phi_pin); else n_pass++;
        n_checks++; if (bus.upd_en !== 1'b0) $display("FAIL rst_upd: got %b expected 0", bus.upd_en); else n_pass++;
        n_checks++; if (bus.step_ack !== 1'b0) $display("FAIL rst_ack: got %b expected 0", bus.step_ack); else n_pass++;
        n_checks++; if (bus.busy !== 1'b0) $display("FAIL rst_busy: got %b expected 0", bus.busy); else n_pass++;
        n_checks++; if (bus.iter_cnt !== 8'd0) $display("FAIL rst_iter: got %0d expected 0", bus.iter_cnt); else n_pass++;
        n_checks++; if (bus.halfcycle_cnt !== 32'd0) $display("FAIL rst_hc: got %0d expected 0", bus.halfcycle_cnt); else n_pass++;
        n_checks++; if (bus.timeout !== 1'b0) $display("FAIL rst_timeout: got %b expected 0", bus.timeout); else n_pass++;
        reset = 1'b0;
        exp_timeout = 1'b0; exp_phi = 1'b0; exp_hc = 0;
        tick();
    endtask

    task automatic test_single_step();
        int ack_cyc, upd, acks;
        for (int i = 0; i < 256; i++) pat[i] = 1'b1;
        bus.settled_i = 1'b1;
        bus.step_req = 1'b1;
        tick();
        bus.step_req = 1'b0;
        n_checks++; if (bus.phi_pin !== 1'b1) $display("FAIL ss_phi_rise: got %b expected 1", bus.phi_pin); else n_pass++;
        n_checks++; if (bus.iter_cnt !== 8'd0) $display("FAIL ss_drive_iter: got %0d expected 0", bus.iter_cnt); else n_pass++;
        n_checks++; if (bus.upd_en !== 1'b0) $display("FAIL ss_drive_upd: got %b expected 0", bus.upd_en); else n_pass++;
        // Finish the half-cycle with the shared stepping loop (already one edge in).
        upd = 0; acks = 0; ack_cyc = -1;
        for (int k = 1; k <= 40; k++) begin
            tick();
            if (bus.upd_en === 1'b1) upd++;
            if (bus.step_ack === 1'b1) begin acks++; if (ack_cyc < 0) ack_cyc = k + 1; end
            if (bus.busy === 1'b0) break;
        end
        exp_phi = 1'b1; exp_hc++;
        n_checks++; if (ack_cyc != 6) $display("FAIL ss_ack_cycle: got %0d expected 6", ack_cyc); else n_pass++;
        n_checks++; if (upd != 4) $display("FAIL ss_upd_cycles: got %0d expected 4", upd); else n_pass++;
        n_checks++; if (acks != 1) $display("FAIL ss_ack_count: got %0d expected 1", acks); else n_pass++;
        n_checks++; if (bus.halfcycle_cnt !== 32'(exp_hc)) $display("FAIL ss_hc: got %0d expected %0d", bus.halfcycle_cnt, exp_hc); else n_pass++;
        n_checks++; if (bus.iter_cnt !== 8'd4) $display("FAIL ss_iter: got %0d expected 4", bus.iter_cnt); else n_pass++;
        n_checks++; if (bus.timeout !== 1'b0) $display("FAIL ss_timeout: got %b expected 0", bus.timeout); else n_pass++;
    endtask

    task automatic test_pattern();
        int ack_cyc, upd, acks, it;
        bit tmo;
        bit seq [0:6] = '{1'b1, 1'b1, 1'b0, 1'b1, 1'b1, 1'b1, 1'b1};
        for (int i = 0; i < 256; i++) pat[i] = (i < 7) ? seq[i] : 1'b0;
        model_step(it, tmo);
        run_step(ack_cyc, upd, acks);
        exp_phi = ~exp_phi; exp_hc++;
        n_checks++; if (bus.iter_cnt !== 8'd7) $display("FAIL pat_iter: got %0d expected 7", bus.iter_cnt); else n_pass++;
        n_checks++; if (bus.timeout !== 1'b0) $display("FAIL pat_timeout: got %b expected 0", bus.timeout); else n_pass++;
        n_checks++; if (ack_cyc != it + 2) $display("FAIL pat_ack_cycle: got %0d expected %0d", ack_cyc, it + 2); else n_pass++;
        n_checks++; if (bus.phi_pin !== exp_phi) $display("FAIL pat_phi: got %b expected %b", bus.phi_pin, exp_phi); else n_pass++;
    endtask

    task automatic test_ignored();
        int acks = 0;
        int hc0 = exp_hc;
        bus.settled_i = 1'b1;
        bus.step_req = 1'b1;
        // step_req stays high across the busy period; no second half-cycle may start.
        for (int k = 0; k < 14; k++) begin
            tick();
            if (k == 5) bus.step_req = 1'b0;
            if (bus.step_ack === 1'b1) acks++;
        end
        exp_hc++; exp_phi = ~exp_phi;
        n_checks++; if (acks != 1) $display("FAIL ign_busy_acks: got %0d expected 1", acks); else n_pass++;
        n_checks++; if (bus.halfcycle_cnt !== 32'(hc0 + 1)) $display("FAIL ign_busy_hc: got %0d expected %0d", bus.halfcycle_cnt, hc0 + 1); else n_pass++;
        acks = 0;
        bus.run = 1'b1; bus.step_req = 1'b1;
        tick();
        bus.run = 1'b0; bus.step_req = 1'b0;
        for (int k = 0; k < 40; k++) begin
            if (bus.step_ack === 1'b1) acks++;
            if (bus.busy === 1'b0) break;
            tick();
        end
        exp_hc++; exp_phi = ~exp_phi;
        n_checks++; if (acks != 0) $display("FAIL ign_run_acks: got %0d expected 0", acks); else n_pass++;
        n_checks++; if (bus.busy !== 1'b0) $display("FAIL ign_run_idle: got %b expected 0", bus.busy); else n_pass++;
        n_checks++; if (bus.halfcycle_cnt !== 32'(exp_hc)) $display("FAIL ign_run_hc: got %0d expected %0d", bus.halfcycle_cnt, exp_hc); else n_pass++;
        n_checks++; if (bus.phi_pin !== exp_phi) $display("FAIL ign_run_phi: got %b expected %b", bus.phi_pin, exp_phi); else n_pass++;
    endtask

    task automatic test_random();
        int ack_cyc, upd, acks, it;
        bit tmo;
        for (int t = 0; t < 10; t++) begin
            int thresh = $urandom_range(4, 10);
            for (int i = 0; i < 256; i++) pat[i] = ($urandom_range(0, 9) < thresh);
            model_step(it, tmo);
            exp_timeout = exp_timeout | tmo;
            run_step(ack_cyc, upd, acks);
            exp_phi = ~exp_phi; exp_hc++;
            n_checks++; if (bus.iter_cnt !== 8'(it)) $display("FAIL rnd_iter[%0d]: got %0d expected %0d", t, bus.iter_cnt, it); else n_pass++;
            n_checks++; if (ack_cyc != it + 2) $display("FAIL rnd_ack_cycle[%0d]: got %0d expected %0d", t, ack_cyc, it + 2); else n_pass++;
            n_checks++; if (upd != it) $display("FAIL rnd_upd[%0d]: got %0d expected %0d", t, upd, it); else n_pass++;
            n_checks++; if (acks != 1) $display("FAIL rnd_acks[%0d]: got %0d expected 1", t, acks); else n_pass++;
            n_checks++; if (bus.timeout !== exp_timeout) $display("FAIL rnd_timeout[%0d]: got %b expected %b", t, bus.timeout, exp_timeout); else n_pass++;
            n_checks++; if (bus.halfcycle_cnt !== 32'(exp_hc)) $display("FAIL rnd_hc[%0d]: got %0d expected %0d", t, bus.halfcycle_cnt, exp_hc); else n_pass++;
            n_checks++; if (bus.phi_pin !== exp_phi) $display("FAIL rnd_phi[%0d]: got %b expected %b", t, bus.phi_pin, exp_phi); else n_pass++;
            for (int k = 0; k < 3; k++) begin bus.settled_i = 1'($urandom_range(0, 1)); tick(); end
            n_checks++; if (bus.iter_cnt !== 8'(it)) $display("FAIL rnd_iter_hold[%0d]: got %0d expected %0d", t, bus.iter_cnt, it); else n_pass++;
        end
    endtask

    task automatic test_reset_mid();
        bus.settled_i = 1'b0;
        bus.step_req = 1'b1;
        tick();
        bus.step_req = 1'b0;
        for (int k = 0; k < 4; k++) tick();
        n_checks++; if (bus.iter_cnt !== 8'd3) $display("FAIL rm_iter_before: got %0d expected 3", bus.iter_cnt); else n_pass++;
        reset = 1'b1;
        tick();
        reset = 1'b0;
        exp_hc = 0; exp_phi = 1'b0; exp_timeout = 1'b0;
        n_checks++; if (bus.busy !== 1'b0) $display("FAIL rm_busy: got %b expected 0", bus.busy); else n_pass++;
        n_checks++; if (bus.upd_en !== 1'b0) $display("FAIL rm_upd: got %b expected 0", bus.upd_en); else n_pass++;
        n_checks++; if (bus.phi_pin !== 1'b0) $display("FAIL rm_phi: got %b expected 0", bus.phi_pin); else n_pass++;
        n_checks++; if (bus.iter_cnt !== 8'd0) $display("FAIL rm_iter: got %0d expected 0", bus.iter_cnt); else n_pass++;
        n_checks++; if (bus.halfcycle_cnt !== 32'd0) $display("FAIL rm_hc: got %0d expected 0", bus.halfcycle_cnt); else n_pass++;
        n_checks++; if (bus.timeout !== 1'b0) $display("FAIL rm_timeout: got %b expected 0", bus.timeout); else n_pass++;
        n_checks++; if (bus.step_ack !== 1'b0) $display("FAIL rm_ack: got %b expected 0", bus.step_ack); else n_pass++;
        tick();
    endtask

    task automatic test_timeout_run();
        int toggles [$];
        int upd = 0;
        bit prev = bus.phi_pin;
        bus.settled_i = 1'b0;
        bus.run = 1'b1;
        for (int k = 0; k < 60; k++) begin
            tick();
            if (bus.phi_pin !== prev) toggles.push_back(k);
            prev = bus.phi_pin;
            if (k < 54 && bus.upd_en === 1'b1) upd++;
            if (k == 16) begin
                n_checks++; if (bus.timeout !== 1'b0) $display("FAIL to_early: got %b expected 0", bus.timeout); else n_pass++;
            end
            if (k == 17) begin
                n_checks++; if (bus.timeout !== 1'b1) $display("FAIL to_set: got %b expected 1", bus.timeout); else n_pass++;
            end
        end
        bus.run = 1'b0;
        n_checks++; if (toggles.size() != 4) $display("FAIL to_toggle_count: got %0d expected 4", toggles.size()); else n_pass++;
        for (int i = 1; i < toggles.size(); i++) begin
            n_checks++; if (toggles[i] - toggles[i-1] != ITER_MAX + 2) $display("FAIL to_period[%0d]: got %0d expected %0d", i, toggles[i] - toggles[i-1], ITER_MAX + 2); else n_pass++;
        end
        n_checks++; if (upd != 3 * ITER_MAX) $display("FAIL to_upd: got %0d expected %0d", upd, 3 * ITER_MAX); else n_pass++;
        for (int k = 0; k < 40 && bus.busy !== 1'b0; k++) tick();
        n_checks++; if (bus.busy !== 1'b0) $display("FAIL to_idle: got %b expected 0", bus.busy); else n_pass++;
        n_checks++; if (bus.halfcycle_cnt !== 32'd4) $display("FAIL to_hc: got %0d expected 4", bus.halfcycle_cnt); else n_pass++;
        n_checks++; if (bus.timeout !== 1'b1) $display("FAIL to_sticky: got %b expected 1", bus.timeout); else n_pass++;
    endtask

    task automatic test_run_stop();
        int acks = 0;
        reset = 1'b1; tick(); reset = 1'b0;
        bus.settled_i = 1'b1;
        bus.run = 1'b1;
        for (int k = 0; k <= 20; k++) begin
            tick();
            if (bus.step_ack === 1'b1) acks++;
        end
        bus.run = 1'b0;
        for (int k = 0; k < 40 && bus.busy !== 1'b0; k++) begin
            tick();
            if (bus.step_ack === 1'b1) acks++;
        end
        n_checks++; if (bus.busy !== 1'b0) $display("FAIL rs_idle: got %b expected 0", bus.busy); else n_pass++;
        n_checks++; if (bus.halfcycle_cnt !== 32'd4) $display("FAIL rs_hc: got %0d expected 4", bus.halfcycle_cnt); else n_pass++;
        n_checks++; if (bus.phi_pin !== 1'b0) $display("FAIL rs_phi: got %b expected 0", bus.phi_pin); else n_pass++;
        n_checks++; if (acks != 0) $display("FAIL rs_acks: got %0d expected 0", acks); else n_pass++;
        n_checks++; if (bus.iter_cnt !== 8'(SETTLE_MIN)) $display("FAIL rs_iter: got %0d expected %0d", bus.iter_cnt, SETTLE_MIN); else n_pass++;
        n_checks++; if (bus.timeout !== 1'b0) $display("FAIL rs_timeout: got %b expected 0", bus.timeout); else n_pass++;
    endtask

    initial begin
        test_reset();
        test_single_step();
        test_pattern();
        test_ignored();
        test_random();
        test_reset_mid();
        test_timeout_run();
        test_run_stop();
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
